// File: rtl/buzzer_arbiter.sv
// Shares one piezo buzzer among N_REQ requesters. Rising-edge requests are latched,
// granted by fixed priority (bit 0 highest), played as timed square waves, and followed by a silent gap.
module buzzer_arbiter #(
  parameter int CLK_HZ = 50_000_000,
  parameter int N_REQ  = 4,
  parameter int HP0    = 35_793,
  parameter int HP1    = 47_778,
  parameter int HP2    = 56_817,
  parameter int HP3    = 75_843,
  parameter int DUR_MS = 100,
  parameter int GAP_MS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             mute,
  output logic             buzzer,
  output logic             busy,
  output logic [1:0]       active_id,
  output logic             done,
  output logic [1:0]       done_id
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int bits_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int HP_MAX   = max2(max2(HP0, HP1), max2(HP2, HP3));
  localparam int TONE_W   = bits_for(HP_MAX);
  localparam int TICK_W   = bits_for(TICK_DIV - 1);
  localparam int MS_W     = bits_for(max2(DUR_MS, GAP_MS));

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state, state_d;
  logic [N_REQ-1:0]    req_q, pending, pending_d, rise, grant_mask, hi_mask;
  logic [TONE_W-1:0]   tone_cnt, tone_cnt_d, hp_sel;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_d;
  logic [MS_W-1:0]     ms_cnt, ms_cnt_d, ms_next;
  logic                tone, tone_d, tick_wrap, done_d, buzzer_d;
  logic [1:0]          active_id_d, done_id_d, grant_id;

  assign rise      = req & ~req_q;
  assign busy      = (state != IDLE);
  assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign ms_next   = ms_cnt + 1'b1;
  assign hi_mask   = (N_REQ'(1) << active_id) - N_REQ'(1);

  always_comb begin
    case (active_id)
      2'd0:    hp_sel = TONE_W'(HP0);
      2'd1:    hp_sel = TONE_W'(HP1);
      2'd2:    hp_sel = TONE_W'(HP2);
      default: hp_sel = TONE_W'(HP3);
    endcase
  end

  always_comb begin
    grant_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) grant_id = 2'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state;
    tone_cnt_d  = tone_cnt;
    tick_cnt_d  = tick_cnt;
    ms_cnt_d    = ms_cnt;
    tone_d      = tone;
    active_id_d = active_id;
    done_d      = 1'b0;
    done_id_d   = done_id;
    grant_mask  = '0;

    case (state)
      IDLE: begin
        if (|pending) begin
          grant_mask[grant_id] = 1'b1;
          active_id_d = grant_id;
          tone_cnt_d  = '0;
          tick_cnt_d  = '0;
          ms_cnt_d    = '0;
          tone_d      = 1'b0;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (tone_cnt == hp_sel) begin
          tone_cnt_d = '0;
          tone_d     = ~tone;
        end else begin
          tone_cnt_d = tone_cnt + 1'b1;
        end
        if (tick_wrap) begin
          tick_cnt_d = '0;
          ms_cnt_d   = ms_next;
        end else begin
          tick_cnt_d = tick_cnt + 1'b1;
        end
        // Natural completion wins over a preemption arriving on the final cycle.
        if (tick_wrap && ms_next == MS_W'(DUR_MS)) begin
          done_d    = 1'b1;
          done_id_d = active_id;
          state_d   = GAP;
        end else if (|(pending & hi_mask)) begin
          state_d = GAP;
        end
        if (state_d == GAP) begin
          tone_cnt_d = '0;
          tick_cnt_d = '0;
          ms_cnt_d   = '0;
          tone_d     = 1'b0;
        end
      end
      GAP: begin
        tone_d = 1'b0;
        if (tick_wrap) begin
          tick_cnt_d = '0;
          ms_cnt_d   = ms_next;
          if (ms_next == MS_W'(GAP_MS)) begin
            ms_cnt_d = '0;
            state_d  = IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A rise on the grant cycle re-arms the bit it would otherwise clear.
    pending_d = (pending & ~grant_mask) | rise;
    buzzer_d  = tone_d & (state_d == PLAY) & ~mute;
  end

  // NOTE: all state uses non-blocking assignment, and the async reset clears the pending latch too,
  // so a reset mid-sound leaves nothing queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      tone_cnt  <= '0;
      tick_cnt  <= '0;
      ms_cnt    <= '0;
      tone      <= 1'b0;
      buzzer    <= 1'b0;
      active_id <= '0;
      done      <= 1'b0;
      done_id   <= '0;
    end else begin
      state     <= state_d;
      req_q     <= req;
      pending   <= pending_d;
      tone_cnt  <= tone_cnt_d;
      tick_cnt  <= tick_cnt_d;
      ms_cnt    <= ms_cnt_d;
      tone      <= tone_d;
      buzzer    <= buzzer_d;
      active_id <= active_id_d;
      done      <= done_d;
      done_id   <= done_id_d;
    end
  end

endmodule
